ahb_slave_mem: RTL

//  AHB slave (responder) for the AHB master interfaces: a word-organised RAM with

---
 rtl/ahb_slave_mem.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ahb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : ahb_slave_mem
// Description : AHB slave RAM, 32-bit word organised, with configurable wait
//               states and two-cycle ERROR responses.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_slave_mem #(
  parameter int ADDR_W      = 6,
  parameter int WIN_W       = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [1:0]  htrans,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic [1:0]  hresp
);

  localparam int         c_DEPTH      = 1 << ADDR_W;
  localparam logic       c_HAS_WAIT   = (WAIT_STATES > 0);
  localparam logic [3:0] c_WAIT_LOAD  = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);
  localparam logic [1:0] c_RESP_OKAY  = 2'b00;
  localparam logic [1:0] c_RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic              r_hreadyout;
  logic              w_hreadyout_nxt;
  logic [1:0]        r_hresp;
  logic [1:0]        w_hresp_nxt;

  logic              r_dp_valid;
  logic              r_dp_write;
  logic              r_dp_err;
  logic [ADDR_W+1:0] r_dp_addr;
  logic [1:0]        r_dp_size;

  logic              w_adv;
  logic              w_accept;
  logic              w_size_err;
  logic              w_align_err;
  logic              w_win_err;
  logic              w_err;
  logic              w_wr_en;
  logic [3:0]        w_be;
  logic [ADDR_W-1:0] w_widx;
  logic [31:0]       w_rword;
  logic              w_unused;

  // Address phase is only taken while this slave is itself ready.
  assign w_adv       = hready & r_hreadyout;
  assign w_accept    = w_adv & hsel & htrans[1];
  assign w_size_err  = (hsize > 3'd2);
  assign w_align_err = ((hsize == 3'd1) & haddr[0]) |
                       ((hsize == 3'd2) & (haddr[1:0] != 2'b00));
  assign w_win_err   = (haddr[WIN_W-1:ADDR_W+2] != '0);
  assign w_err       = w_size_err | w_align_err | w_win_err;
  assign w_unused    = ^{hburst, haddr[31:WIN_W], htrans[0]};

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_err   <= 1'b0;
      r_dp_addr  <= '0;
      r_dp_size  <= 2'd0;
    end else if (w_adv) begin
      r_dp_valid <= w_accept;
      if (w_accept) begin
        r_dp_write <= hwrite;
        r_dp_err   <= w_err;
        r_dp_addr  <= haddr[ADDR_W+1:0];
        r_dp_size  <= hsize[1:0];
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state     <= ST_OK;
      r_cnt       <= 4'd0;
      r_hreadyout <= 1'b1;
      r_hresp     <= c_RESP_OKAY;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hreadyout <= w_hreadyout_nxt;
      r_hresp     <= w_hresp_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_hreadyout_nxt = 1'b1;
    w_hresp_nxt     = c_RESP_OKAY;
    case (r_state)
      ST_OK, ST_ERR2: begin
        if (!w_accept) begin
          w_state_nxt = ST_OK;
        end else if (w_err) begin
          w_state_nxt = ST_ERR1;
        end else if (c_HAS_WAIT) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = c_WAIT_LOAD;
        end else begin
          w_state_nxt = ST_OK;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_OK;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_ERR1: w_state_nxt = ST_ERR2;
      default: w_state_nxt = ST_OK;
    endcase
    // Outputs are registered versions of the next-state decode.
    w_hreadyout_nxt = (w_state_nxt == ST_OK) || (w_state_nxt == ST_ERR2);
    w_hresp_nxt     = ((w_state_nxt == ST_ERR1) || (w_state_nxt == ST_ERR2)) ?
                      c_RESP_ERROR : c_RESP_OKAY;
  end

  assign w_wr_en = r_dp_valid & r_hreadyout & ~r_dp_err & r_dp_write;
  assign w_widx  = r_dp_addr[ADDR_W+1:2];

  always_comb begin
    w_be = 4'b0000;
    case (r_dp_size)
      2'd0:    w_be = 4'b0001 << r_dp_addr[1:0];
      2'd1:    w_be = r_dp_addr[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  // One byte-wide array per lane keeps each lane's write port independent.
  for (genvar b = 0; b < 4; b++) begin : g_lane
    logic [7:0] r_lane [c_DEPTH];

    always_ff @(posedge hclk) begin
      if (w_wr_en && w_be[b]) begin
        r_lane[w_widx] <= hwdata[8*b +: 8];
      end
    end

    assign w_rword[8*b +: 8] = r_lane[w_widx];
  end

  assign hrdata    = (r_dp_valid & ~r_dp_write & ~r_dp_err) ? w_rword : 32'h0;
  assign hreadyout = r_hreadyout;
  assign hresp     = r_hresp;

endmodule
`default_nettype wire
